// File: rtl/vga_text_renderer.sv
// Text-mode pixel renderer: maps line/column to a character cell, looks the
// symbol up in a self-clearing text buffer and drives a 3-stage RGB pipeline.

module fontMem (
  input  logic [2:0] px,
  input  logic [3:0] py,
  input  logic [7:0] symbolCode,
  output logic       onoff
);
  // 8x16 glyphs, glyph row 0 in the top byte, pixel 0 in bit 7 of each row.
  localparam logic [127:0] G_0 = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
  localparam logic [127:0] G_1 = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
  localparam logic [127:0] G_2 = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
  localparam logic [127:0] G_3 = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
  localparam logic [127:0] G_4 = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
  localparam logic [127:0] G_5 = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
  localparam logic [127:0] G_6 = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
  localparam logic [127:0] G_7 = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
  localparam logic [127:0] G_8 = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
  localparam logic [127:0] G_9 = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
  localparam logic [127:0] G_A = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
  localparam logic [127:0] G_B = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;
  localparam logic [127:0] G_C = 128'h0000_3C66_C2C0_C0C0_C0C2_663C_0000_0000;
  localparam logic [127:0] G_D = 128'h0000_F86C_6666_6666_6666_6CF8_0000_0000;
  localparam logic [127:0] G_E = 128'h0000_FE66_6268_7868_6062_66FE_0000_0000;
  localparam logic [127:0] G_F = 128'h0000_FE66_6268_7868_6060_60F0_0000_0000;
  localparam logic [127:0] G_BLOCK = '1;

  logic [127:0] glyph;
  logic [7:0]   row;

  always_comb begin
    case (symbolCode)
      8'h30:   glyph = G_0;
      8'h31:   glyph = G_1;
      8'h32:   glyph = G_2;
      8'h33:   glyph = G_3;
      8'h34:   glyph = G_4;
      8'h35:   glyph = G_5;
      8'h36:   glyph = G_6;
      8'h37:   glyph = G_7;
      8'h38:   glyph = G_8;
      8'h39:   glyph = G_9;
      8'h41:   glyph = G_A;
      8'h42:   glyph = G_B;
      8'h43:   glyph = G_C;
      8'h44:   glyph = G_D;
      8'h45:   glyph = G_E;
      8'h46:   glyph = G_F;
      8'hDB:   glyph = G_BLOCK;
      default: glyph = '0;
    endcase
    row   = 8'(glyph >> {(4'd15 - py), 3'b000});
    onoff = row[3'd7 - px];
  end
endmodule

module vga_text_renderer #(
  parameter int unsigned COLS         = 20,
  parameter int unsigned ROWS         = 8,
  parameter int unsigned SCALE_LOG2   = 3,
  parameter int unsigned H_ACTIVE     = 1280,
  parameter int unsigned V_ACTIVE     = 1024,
  parameter int unsigned BLINK_FRAMES = 32,
  localparam int unsigned N           = COLS * ROWS,
  localparam int unsigned ADDR_W      = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [11:0]       line,
  input  logic [11:0]       column,
  input  logic [11:0]       fg_color,
  input  logic [11:0]       bg_color,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              cursor_en,
  input  logic [ADDR_W-1:0] cursor_addr,
  output logic              busy,
  output logic [11:0]       RGBsig
);
  localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_we;

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      CLEAR:   if (clr_addr == ADDR_W'(N - 1)) state_n = RUN;
      RUN:     state_n = RUN;
      default: state_n = CLEAR;
    endcase
  end

  always_comb begin
    busy   = (state == CLEAR);
    clr_we = (state == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (reset)               clr_addr <= '0;
    else if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
  end

  // Writes are registered one cycle before reaching the array so that a
  // lookup issued in the same cycle as a write still reads the old symbol.
  logic              we_c, we_q;
  logic [ADDR_W-1:0] wa_c, wa_q;
  logic [7:0]        wd_c, wd_q;

  always_comb begin
    we_c = clr_we || (state == RUN && wr_en && 32'(wr_addr) < N);
    wa_c = clr_we ? clr_addr : wr_addr;
    wd_c = clr_we ? 8'h20 : wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= we_c;
      wa_q <= wa_c;
      wd_q <= wd_c;
    end
  end

  logic [11:0]       cx, cy;
  logic [2:0]        px1;
  logic [3:0]        py1;
  logic              act1, cur1;
  logic [ADDR_W-1:0] addr1;

  always_comb begin
    cx    = column >> (3 + SCALE_LOG2);
    cy    = line >> (4 + SCALE_LOG2);
    px1   = 3'(column >> SCALE_LOG2);
    py1   = 4'(line >> SCALE_LOG2);
    act1  = (32'(line) < V_ACTIVE) && (32'(column) < H_ACTIVE) &&
            (32'(cx) < COLS) && (32'(cy) < ROWS);
    addr1 = ADDR_W'(32'(cy) * COLS + 32'(cx));
    cur1  = cursor_en && (addr1 == cursor_addr);
  end

  logic [ADDR_W-1:0] s1_addr;
  logic [2:0]        s1_px, s2_px;
  logic [3:0]        s1_py, s2_py;
  logic              s1_active, s1_cur, s2_active, s2_cur;
  logic [7:0]        symbolCode;
  logic [7:0]        tbuf [N];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_active <= 1'b0;
      s1_cur    <= 1'b0;
      s1_addr   <= '0;
      s1_px     <= '0;
      s1_py     <= '0;
      s2_active <= 1'b0;
      s2_cur    <= 1'b0;
      s2_px     <= '0;
      s2_py     <= '0;
    end else begin
      s1_active <= act1 && (state == RUN);
      s1_cur    <= cur1;
      s1_addr   <= act1 ? addr1 : '0;
      s1_px     <= px1;
      s1_py     <= py1;
      s2_active <= s1_active;
      s2_cur    <= s1_cur;
      s2_px     <= s1_px;
      s2_py     <= s1_py;
    end
  end

  always_ff @(posedge clk) begin
    if (we_q) tbuf[wa_q] <= wd_q;
    symbolCode <= tbuf[s1_addr];
  end

  logic             at00, prev00, tick, blink_phase;
  logic [FC_W-1:0]  frame_cnt;

  always_comb begin
    at00 = (line == 12'd0) && (column == 12'd0);
    tick = at00 && !prev00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev00      <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      prev00 <= at00;
      if (tick) begin
        if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  logic onoff;

  fontMem u_font (
    .px         (s2_px),
    .py         (s2_py),
    .symbolCode (symbolCode),
    .onoff      (onoff)
  );

  always_ff @(posedge clk) begin
    if (reset)                            RGBsig <= '0;
    else if (state != RUN || !s2_active)  RGBsig <= '0;
    else if (onoff ^ (s2_cur && blink_phase)) RGBsig <= fg_color;
    else                                  RGBsig <= bg_color;
  end
endmodule

// File: tb/tb_vga_text_renderer.sv
// Scoreboard bench: the driver pushes expected pixels, the monitor pops them
// three cycles later and also tracks busy against the clear-duration model.

module tb_vga_text_renderer;
  localparam int unsigned COLS = 20;
  localparam int unsigned ROWS = 8;
  localparam int unsigned N    = 160;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] line, column, fg_color, bg_color;
  logic        wr_en, cursor_en, busy;
  logic [7:0]  wr_addr, wr_data, cursor_addr;
  logic [11:0] RGBsig;

  always #5 clk = ~clk;

  vga_text_renderer #(.BLINK_FRAMES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .line        (line),
    .column      (column),
    .fg_color    (fg_color),
    .bg_color    (bg_color),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .cursor_en   (cursor_en),
    .cursor_addr (cursor_addr),
    .busy        (busy),
    .RGBsig      (RGBsig)
  );

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] exp;
  } sb_t;

  sb_t         sb[$];
  logic [2:0]  vpipe = '0;
  logic        drv_valid = 1'b0;
  logic        chk_busy = 1'b0;
  logic        done = 1'b0;
  int unsigned exp_cnt = 0;
  int          errors = 0;
  int          checks = 0;
  int          nprint = 0;

  logic [7:0]  tm [N];
  logic        m_prev = 1'b0;
  logic        m_phase = 1'b0;
  int unsigned m_cnt = 0;
  logic [7:0]  glyph_a [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                                8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};

  always @(posedge clk) begin
    vpipe <= {vpipe[1:0], drv_valid};
    if (reset)        exp_cnt <= 0;
    else if (exp_cnt < N) exp_cnt <= exp_cnt + 1;
  end

  function automatic logic [11:0] model_pix(input int unsigned x, input int unsigned y);
    int unsigned cx, cy, a;
    logic [7:0]  row;
    logic        bitv, inv;
    if (x >= 1280 || y >= 1024) return 12'h000;
    cx = x >> 6;
    cy = y >> 7;
    if (cx >= COLS || cy >= ROWS) return 12'h000;
    a    = cy * COLS + cx;
    row  = (tm[a] == 8'h41) ? glyph_a[(y >> 3) & 15] : 8'h00;
    bitv = row[7 - ((x >> 3) & 7)];
    inv  = cursor_en && (a == 32'(cursor_addr)) && m_phase;
    return (bitv ^ inv) ? fg_color : bg_color;
  endfunction

  task automatic cyc(input int unsigned x, input int unsigned y,
                     input logic we = 1'b0, input int unsigned wa = 0,
                     input logic [7:0] wd = 8'h00);
    logic [11:0] e;
    logic        bsy;
    line    = 12'(y);
    column  = 12'(x);
    wr_en   = we;
    wr_addr = 8'(wa);
    wr_data = wd;
    bsy     = (exp_cnt < N);
    if (reset) begin
      m_prev  = 1'b0;
      m_cnt   = 0;
      m_phase = 1'b0;
      for (int i = 0; i < int'(N); i++) tm[i] = 8'h20;
      e = 12'h000;
    end else begin
      if (x == 0 && y == 0 && !m_prev) begin
        if (m_cnt == 1) begin
          m_cnt   = 0;
          m_phase = ~m_phase;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      m_prev = (x == 0 && y == 0);
      e = bsy ? 12'h000 : model_pix(x, y);
      if (we && !bsy && wa < N) tm[wa] = wd;
    end
    sb.push_back('{x: 12'(x), y: 12'(y), exp: e});
    drv_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic scan_screen();
    for (int yy = 0; yy < 64; yy++)
      for (int xx = 0; xx < 160; xx++)
        cyc(8 * xx + 3, 16 * yy + 5);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (chk_busy) begin
      checks++;
      if (busy !== (exp_cnt < N)) begin
        errors++;
        if (nprint < 50) $display("FAIL busy: got %b want %b at %0t", busy, (exp_cnt < N), $time);
        nprint++;
      end
    end
    if (vpipe[2]) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow at %0t", $time);
      end else begin
        e = sb.pop_front();
        if (RGBsig !== e.exp) begin
          errors++;
          if (nprint < 50)
            $display("FAIL rgb(x=%0d,y=%0d): got %h want %h", e.x, e.y, RGBsig, e.exp);
          nprint++;
        end
      end
    end
    if (done) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    line = 12'd0; column = 12'd4000;
    fg_color = 12'hFFF; bg_color = 12'h00F;
    wr_en = 1'b0; wr_addr = 8'd0; wr_data = 8'd0;
    cursor_en = 1'b0; cursor_addr = 8'd0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_busy = 1'b1;
    cyc(4000, 0);
    reset = 1'b0;

    // 80 clear cycles, including an ignored write of 'A' to cell 5.
    for (int i = 0; i < 80; i++) begin
      if (i == 10) cyc(100, 100, 1'b1, 5, 8'h41);
      else         cyc(8 * i, 16 + i);
    end
    reset = 1'b1;
    cyc(4000, 0);
    reset = 1'b0;
    for (int i = 0; i < 165; i++) cyc(10 * i + 1, 3 * i);

    scan_screen();

    cyc(1280, 5);
    cyc(5, 1024);
    cyc(4095, 4095);
    cyc(1279, 1023);

    cyc(4000, 0, 1'b1, 21, 8'h41);
    for (int y = 128; y < 256; y++)
      for (int x = 64; x < 128; x++)
        cyc(x, y);

    cyc(4000, 0, 1'b1, 200, 8'h41);
    scan_screen();

    cyc(216, 16, 1'b1, 3, 8'h41);
    cyc(216, 16);
    cyc(216, 16);

    cursor_en = 1'b1;
    cursor_addr = 8'd0;
    cyc(20, 40);
    cyc(63, 127);
    for (int f = 1; f < 6; f++) begin
      cyc(4000, 0);
      cyc(4000, 0);
      repeat ((f == 1) ? 5 : 1) cyc(0, 0);
      cyc(20, 40);
      cyc(63, 127);
    end

    drv_valid = 1'b0;
    wr_en = 1'b0;
    column = 12'd4000;
    repeat (4) @(posedge clk);
    done = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL summary_not_reached");
    $fatal(1);
  end
endmodule

// File: doc/vga_text_renderer.md
# vga_text_renderer

Parametrised, pipelined text-mode pixel renderer for the VGA output path. It maps the timing generator's `line`/`column` to a character cell and glyph pixel, then drives `RGBsig`. It owns a writable on-chip text buffer that is cleared to spaces after reset, supports runtime foreground/background colours, and draws a blinking inverse-video cursor. It reuses the existing `fontMem` glyph ROM (8×16 glyphs) and sits between the VGA sync generator and the DAC pins.

## Interface
Parameters:
- `COLS`, default 20: text columns.
- `ROWS`, default 8: text rows.
- `SCALE_LOG2`, default 3: each glyph pixel is 2^SCALE_LOG2 × 2^SCALE_LOG2 screen pixels.
- `H_ACTIVE`, default 1280: visible width.
- `V_ACTIVE`, default 1024: visible height.
- `BLINK_FRAMES`, default 32: frames per cursor phase, ≥1.
- Localparams: `N = COLS*ROWS`, `ADDR_W = $clog2(N)`.

Ports (clock and reset first):
- `clk` in 1: pixel clock.
- `reset` in 1: synchronous, active-high.
- `line` in 12: current scan line from the timing generator.
- `column` in 12: current pixel column.
- `fg_color` in 12: glyph-on colour, {B,G,R} 4 bits each.
- `bg_color` in 12: glyph-off colour.
- `wr_en` in 1: text buffer write strobe.
- `wr_addr` in ADDR_W: cell index, row*COLS+col.
- `wr_data` in 8: symbol code.
- `cursor_en` in 1: enables the cursor.
- `cursor_addr` in ADDR_W: cursor cell index.
- `busy` out 1: high while the clear FSM runs.
- `RGBsig` out 12: pixel colour, registered.

## Operation
- FSM states:
  - CLEAR: entered on any cycle with `reset`=1, and a reset during CLEAR restarts it from address 0. Writes 8'h20 to address `clr_addr`, starting at 0, once per cycle after reset is released. After address N-1 it goes to RUN.
  - RUN: remains here until the next reset.
- While in CLEAR, `busy` is 1, `wr_en` is ignored, and `RGBsig` is forced to 0.
- Text buffer: N×8, one write port and one synchronous read port. A write happens when RUN && `wr_en` && `wr_addr` < N. Writes with an out-of-range address are dropped silently.
- Read and write to the same address in the same cycle return the old data (read-first).
- Stage 1 (registered) computes:
  - `cx = column >> (3+SCALE_LOG2)`
  - `cy = line >> (4+SCALE_LOG2)`
  - `px = (column >> SCALE_LOG2)[2:0]`
  - `py = (line >> SCALE_LOG2)[3:0]`
  - `active = line<V_ACTIVE && column<H_ACTIVE && cx<COLS && cy<ROWS`
  - `addr = cy*COLS+cx`, truncated to ADDR_W and used only when `active`
  - `is_cur = cursor_en && addr==cursor_addr`
- Stage 2: the text buffer read produces `symbolCode`. `px`, `py`, `active` and `is_cur` are carried along.
- Stage 3 (registered output):
  - `fontMem(px,py,symbolCode)` gives `onoff`.
  - `inv = is_cur && blink_phase`.
  - `RGBsig = !active ? 0 : (onoff ^ inv) ? fg_color : bg_color`.
- Frame tick: a one-cycle pulse when `line==0 && column==0` and the previous cycle's (line,column) was not (0,0). A held (0,0) produces one tick only.
- Blink: `frame_cnt` counts ticks from 0 to BLINK_FRAMES-1. On wrap it clears and toggles `blink_phase`.
- `fg_color`, `bg_color` and cursor inputs are sampled at the stage that uses them. There is no shadowing.

## Timing
- Latency: `line`/`column` presented in cycle t produce `RGBsig` at cycle t+3.
- A text write in cycle t is visible to a stage-1 lookup issued in cycle t+1 or later.
- Clear duration: the last reset-high cycle is r. Addresses 0..N-1 are written in cycles r+1..r+N. `busy` is high through cycle r+N and low from r+N+1.
- Reset values:
  - `RGBsig`=0, `busy`=1
  - `blink_phase`=0, `frame_cnt`=0
  - pipeline `active` flags=0, previous-(0,0) flag=0
- `RGBsig` stays 0 for 3 cycles after RUN is entered; valid output follows.
- With BLINK_FRAMES=1 the cursor toggles on every frame tick.
- Throughput is one pixel per clock with no stalls.

## Test plan
- Reset for 2 cycles, default params → `busy` high for exactly 160 cycles after release. A full-screen scan then yields `bg_color`=12'h00F everywhere, because the space glyph is blank.
- After clear, write 8'h41 at address 21 (row 1, col 1). Scan x∈[64,128), y∈[128,256) → `RGBsig` equals `fontMem('A')` expanded 8× (on = `fg_color` 12'hFFF, off = `bg_color`), exactly 3 cycles after each input.
- Drive column=1280 or line=1024 → `RGBsig`=0 at t+3. `wr_en` with `wr_addr`=200 → no cell changes (full-screen compare).
- BLINK_FRAMES=2, `cursor_en`=1, `cursor_addr`=0, cell 0 holds a space → cell 0 shows `bg_color` for frames 0–1, `fg_color` for frames 2–3, then repeats. Holding (0,0) for 5 cycles counts one frame.
- `wr_en` during `busy` at address 5 with 8'h41 → cell 5 stays a space. Asserting `reset` at clear cycle 80 → `busy` lasts 160 cycles from the new release.
- Same-cycle write 8'h41 and stage-1 lookup of address 3 → the old glyph is shown. The next lookup of address 3 shows 'A'.
